// File: rtl/sm_pkg.sv
// Shared types and constants for the SM fetch path.
package sm_pkg;

    localparam int unsigned NUM_WARP   = 8;
    localparam int unsigned DEPTH_WARP = 3;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned INST_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } warp_state_e;

    // Payload held in the code-memory request register
    typedef struct packed {
        logic [DEPTH_WARP-1:0] wid;
        logic [ADDR_W-1:0]     addr;
    } fetch_req_t;

endpackage

// File: rtl/sm_rr_arbiter.sv
// Round-robin picker: first requesting warp at or after the pointer, wrapping.
module sm_rr_arbiter
    import sm_pkg::*;
(
    input  logic [NUM_WARP-1:0]   req,
    input  logic [DEPTH_WARP-1:0] ptr,
    output logic [NUM_WARP-1:0]   gnt,
    output logic                  gnt_valid,
    output logic [DEPTH_WARP-1:0] gnt_id
);

    logic [DEPTH_WARP-1:0] idx;

    // Scan from the pointer; the index add wraps in DEPTH_WARP bits
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_WARP; i++) begin
            idx = ptr + DEPTH_WARP'(i);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx;
            end
        end
        gnt = gnt_valid ? (NUM_WARP'(1) << gnt_id) : '0;
    end

endmodule

// File: rtl/sm_fetch_sched.sv
// Per-warp fetch scheduler: shares the code-memory read port between resident warps.
module sm_fetch_sched
    import sm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  warp_start_valid_i,
    input  logic [DEPTH_WARP-1:0] warp_start_wid_i,
    input  logic [ADDR_W-1:0]     warp_start_addr_i,
    input  logic                  warp_end_valid_i,
    input  logic [DEPTH_WARP-1:0] warp_end_wid_i,
    input  logic                  branch_valid_i,
    input  logic [DEPTH_WARP-1:0] branch_wid_i,
    input  logic [ADDR_W-1:0]     branch_target_i,
    input  logic [NUM_WARP-1:0]   inst_buffer_avail_i,
    input  logic [NUM_WARP-1:0]   stalled_warps_i,
    input  logic                  code_mem_ready_i,
    output logic                  code_rd_req_valid_o,
    output logic [ADDR_W-1:0]     code_rd_req_addr_o,
    output logic [DEPTH_WARP-1:0] code_rd_req_wid_o,
    input  logic                  code_rd_rsp_valid_i,
    input  logic [DEPTH_WARP-1:0] code_rd_rsp_wid_i,
    input  logic [ADDR_W-1:0]     code_rd_rsp_addr_i,
    output logic                  rsp_drop_o,
    output logic [NUM_WARP-1:0]   active_warps_o
);

    warp_state_e           state_q [NUM_WARP];
    warp_state_e           state_d [NUM_WARP];
    logic [ADDR_W-1:0]     pc_q    [NUM_WARP];
    logic [ADDR_W-1:0]     pc_d    [NUM_WARP];
    logic [NUM_WARP-1:0]   stale_q;
    logic [NUM_WARP-1:0]   stale_d;
    logic [DEPTH_WARP-1:0] rr_ptr_q;
    logic [DEPTH_WARP-1:0] rr_ptr_d;
    logic                  req_valid_q;
    logic                  req_valid_d;
    fetch_req_t            req_q;
    fetch_req_t            req_d;

    logic                  xfer;
    logic                  load_en;
    logic [NUM_WARP-1:0]   start_hit;
    logic [NUM_WARP-1:0]   end_hit;
    logic [NUM_WARP-1:0]   branch_hit;
    logic [NUM_WARP-1:0]   rsp_hit;
    logic [NUM_WARP-1:0]   held;
    logic [NUM_WARP-1:0]   xfer_hit;
    logic [NUM_WARP-1:0]   eligible;
    logic [NUM_WARP-1:0]   arb_req;
    logic [NUM_WARP-1:0]   gnt_onehot;
    logic                  gnt_valid;
    logic [DEPTH_WARP-1:0] gnt_id;
    logic [ADDR_W-1:0]     gnt_pc;

    // Decode events into per-warp one-hot vectors and compute eligibility
    always_comb begin
        xfer       = req_valid_q & code_mem_ready_i;
        load_en    = ~req_valid_q | xfer;
        start_hit  = warp_start_valid_i  ? (NUM_WARP'(1) << warp_start_wid_i)  : '0;
        end_hit    = warp_end_valid_i    ? (NUM_WARP'(1) << warp_end_wid_i)    : '0;
        branch_hit = branch_valid_i      ? (NUM_WARP'(1) << branch_wid_i)      : '0;
        rsp_hit    = code_rd_rsp_valid_i ? (NUM_WARP'(1) << code_rd_rsp_wid_i) : '0;
        held       = req_valid_q         ? (NUM_WARP'(1) << req_q.wid)         : '0;
        xfer_hit   = xfer ? held : '0;
        eligible   = '0;
        // End and branch both outrank a grant to the same warp
        for (int unsigned w = 0; w < NUM_WARP; w++) begin
            eligible[w] = (state_q[w] == READY) & inst_buffer_avail_i[w] & ~stalled_warps_i[w]
                        & ~held[w] & ~end_hit[w] & ~branch_hit[w];
        end
        arb_req = load_en ? eligible : '0;
    end

    sm_rr_arbiter u_rr_arbiter (
        .req       (arb_req),
        .ptr       (rr_ptr_q),
        .gnt       (gnt_onehot),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // One-hot mux of the granted warp's PC
    always_comb begin
        gnt_pc = '0;
        for (int unsigned w = 0; w < NUM_WARP; w++) begin
            if (gnt_onehot[w]) begin
                gnt_pc = gnt_pc | pc_q[w];
            end
        end
    end

    // Responses are dropped unless they match the warp's single live fetch
    always_comb begin
        rsp_drop_o = code_rd_rsp_valid_i
                   & (stale_q[code_rd_rsp_wid_i]
                   | (state_q[code_rd_rsp_wid_i] != PEND)
                   | (code_rd_rsp_addr_i != pc_q[code_rd_rsp_wid_i])
                   | end_hit[code_rd_rsp_wid_i]
                   | branch_hit[code_rd_rsp_wid_i]);
    end

    // Next-state for every warp plus the RR pointer and request register
    always_comb begin
        stale_d     = stale_q;
        rr_ptr_d    = rr_ptr_q;
        req_valid_d = req_valid_q;
        req_d       = req_q;
        for (int unsigned w = 0; w < NUM_WARP; w++) begin
            state_d[w] = state_q[w];
            pc_d[w]    = pc_q[w];
        end

        for (int unsigned w = 0; w < NUM_WARP; w++) begin
            case (state_q[w])
                IDLE: begin
                    if (start_hit[w]) begin
                        state_d[w] = READY;
                        pc_d[w]    = warp_start_addr_i;
                        stale_d[w] = 1'b0;
                    end
                end
                READY: begin
                    if (end_hit[w]) begin
                        state_d[w] = IDLE;
                        stale_d[w] = 1'b0;
                    end else begin
                        // A request already in flight to memory carries the old PC
                        if (branch_hit[w]) begin
                            pc_d[w] = branch_target_i;
                            if (held[w]) begin
                                stale_d[w] = 1'b1;
                            end
                        end
                        if (xfer_hit[w]) begin
                            state_d[w] = PEND;
                        end
                    end
                end
                PEND: begin
                    if (end_hit[w]) begin
                        // A response landing in the same cycle closes the drain at once
                        state_d[w] = rsp_hit[w] ? IDLE : DRAIN;
                        stale_d[w] = 1'b0;
                    end else if (branch_hit[w]) begin
                        pc_d[w] = branch_target_i;
                        if (rsp_hit[w]) begin
                            state_d[w] = READY;
                            stale_d[w] = 1'b0;
                        end else begin
                            stale_d[w] = 1'b1;
                        end
                    end else if (rsp_hit[w]) begin
                        state_d[w] = READY;
                        stale_d[w] = 1'b0;
                        if (!stale_q[w] && (code_rd_rsp_addr_i == pc_q[w])) begin
                            pc_d[w] = pc_q[w] + ADDR_W'(INST_BYTES);
                        end
                    end
                end
                DRAIN: begin
                    if (rsp_hit[w]) begin
                        state_d[w] = IDLE;
                        stale_d[w] = 1'b0;
                    end
                end
                default: state_d[w] = IDLE;
            endcase
        end

        if (gnt_valid) begin
            rr_ptr_d = gnt_id + DEPTH_WARP'(1);
        end

        if (load_en) begin
            req_valid_d = gnt_valid;
            if (gnt_valid) begin
                req_d.wid  = gnt_id;
                req_d.addr = gnt_pc;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned w = 0; w < NUM_WARP; w++) begin
                state_q[w] <= IDLE;
                pc_q[w]    <= '0;
            end
            stale_q     <= '0;
            rr_ptr_q    <= '0;
            req_valid_q <= 1'b0;
            req_q       <= '0;
        end else begin
            for (int unsigned w = 0; w < NUM_WARP; w++) begin
                state_q[w] <= state_d[w];
                pc_q[w]    <= pc_d[w];
            end
            stale_q     <= stale_d;
            rr_ptr_q    <= rr_ptr_d;
            req_valid_q <= req_valid_d;
            req_q       <= req_d;
        end
    end

    // Active vector is read straight from the state flops
    always_comb begin
        active_warps_o = '0;
        for (int unsigned w = 0; w < NUM_WARP; w++) begin
            active_warps_o[w] = (state_q[w] != IDLE);
        end
    end

    assign code_rd_req_valid_o = req_valid_q;
    assign code_rd_req_addr_o  = req_q.addr;
    assign code_rd_req_wid_o   = req_q.wid;

endmodule

// File: tb/tb_sm_fetch_sched.sv
// Self-checking bench for sm_fetch_sched: directed scenarios plus randomized traffic
// against a behavioural warp model with an in-order code-memory responder.
module tb_sm_fetch_sched;
    import sm_pkg::*;

    localparam int M_IDLE  = 0;
    localparam int M_READY = 1;
    localparam int M_PEND  = 2;
    localparam int M_DRAIN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  start_v;
    logic [DEPTH_WARP-1:0] start_w;
    logic [ADDR_W-1:0]     start_a;
    logic                  end_v;
    logic [DEPTH_WARP-1:0] end_w;
    logic                  br_v;
    logic [DEPTH_WARP-1:0] br_w;
    logic [ADDR_W-1:0]     br_t;
    logic [NUM_WARP-1:0]   avail;
    logic [NUM_WARP-1:0]   stall;
    logic                  ready;
    logic                  req_valid;
    logic [ADDR_W-1:0]     req_addr;
    logic [DEPTH_WARP-1:0] req_wid;
    logic                  rsp_v;
    logic [DEPTH_WARP-1:0] rsp_w;
    logic [ADDR_W-1:0]     rsp_a;
    logic                  drop;
    logic [NUM_WARP-1:0]   active;

    sm_fetch_sched dut (
        .clk                 (clk),
        .rst                 (rst),
        .warp_start_valid_i  (start_v),
        .warp_start_wid_i    (start_w),
        .warp_start_addr_i   (start_a),
        .warp_end_valid_i    (end_v),
        .warp_end_wid_i      (end_w),
        .branch_valid_i      (br_v),
        .branch_wid_i        (br_w),
        .branch_target_i     (br_t),
        .inst_buffer_avail_i (avail),
        .stalled_warps_i     (stall),
        .code_mem_ready_i    (ready),
        .code_rd_req_valid_o (req_valid),
        .code_rd_req_addr_o  (req_addr),
        .code_rd_req_wid_o   (req_wid),
        .code_rd_rsp_valid_i (rsp_v),
        .code_rd_rsp_wid_i   (rsp_w),
        .code_rd_rsp_addr_i  (rsp_a),
        .rsp_drop_o          (drop),
        .active_warps_o      (active)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: warp table, outstanding request slot, RR pointer
    int          ms     [NUM_WARP];
    logic [31:0] mpc    [NUM_WARP];
    bit          mstale [NUM_WARP];
    int          mptr;
    bit          mrv;
    int          mrw;
    logic [31:0] mra;

    bit          auto_rsp;
    int          q_wid  [$];
    logic [31:0] q_addr [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        for (int w = 0; w < NUM_WARP; w++) begin
            ms[w] = M_IDLE; mpc[w] = '0; mstale[w] = 1'b0;
        end
        mptr = 0; mrv = 1'b0; mrw = 0; mra = '0;
    endfunction

    function automatic bit m_elig(input int w);
        return (ms[w] == M_READY) && avail[w] && !stall[w] && !(mrv && mrw == w)
            && !(end_v && int'(end_w) == w) && !(br_v && int'(br_w) == w);
    endfunction

    function automatic bit m_drop();
        int r;
        if (!rsp_v) return 1'b0;
        r = int'(rsp_w);
        return mstale[r] || (ms[r] != M_PEND) || (rsp_a != mpc[r])
            || (end_v && int'(end_w) == r) || (br_v && int'(br_w) == r);
    endfunction

    function automatic void clear_events();
        start_v = 1'b0; end_v = 1'b0; br_v = 1'b0; rsp_v = 1'b0;
    endfunction

    // Compare DUT outputs with the model on the falling edge
    task automatic sample();
        logic [31:0] ea;
        @(negedge clk);
        ea = '0;
        for (int w = 0; w < NUM_WARP; w++) if (ms[w] != M_IDLE) ea[w] = 1'b1;
        chk("req_valid", 32'(req_valid), 32'(mrv));
        if (mrv) begin
            chk("req_addr", req_addr, mra);
            chk("req_wid", 32'(req_wid), 32'(mrw));
        end
        chk("active", 32'(active), ea);
        chk("rsp_drop", 32'(drop), 32'(m_drop()));
        if (auto_rsp && mrv && ready) begin
            q_wid.push_back(mrw);
            q_addr.push_back(mra);
        end
    endtask

    // Step the model with this cycle's inputs and move past the clock edge
    task automatic advance();
        int          n_ms  [NUM_WARP];
        logic [31:0] n_pc  [NUM_WARP];
        bit          n_st  [NUM_WARP];
        int          n_ptr;
        bit          n_rv;
        int          n_rw;
        logic [31:0] n_ra;
        bit          xfer;
        bit          canload;
        int          g;
        n_ms = ms; n_pc = mpc; n_st = mstale;
        n_ptr = mptr; n_rv = mrv; n_rw = mrw; n_ra = mra;
        if (rst) begin
            for (int w = 0; w < NUM_WARP; w++) begin
                n_ms[w] = M_IDLE; n_pc[w] = '0; n_st[w] = 1'b0;
            end
            n_ptr = 0; n_rv = 1'b0; n_rw = 0; n_ra = '0;
        end else begin
            xfer    = mrv && ready;
            canload = !mrv || xfer;
            g       = -1;
            if (canload) begin
                for (int k = 0; k < NUM_WARP; k++) begin
                    int c;
                    c = (mptr + k) % NUM_WARP;
                    if (g < 0 && m_elig(c)) g = c;
                end
            end
            for (int w = 0; w < NUM_WARP; w++) begin
                bit e, b, r, x, s, h;
                e = end_v && int'(end_w) == w;
                b = br_v && int'(br_w) == w;
                r = rsp_v && int'(rsp_w) == w;
                s = start_v && int'(start_w) == w;
                h = mrv && mrw == w;
                x = xfer && h;
                case (ms[w])
                    M_IDLE: if (s) begin n_ms[w] = M_READY; n_pc[w] = start_a; n_st[w] = 1'b0; end
                    M_READY: begin
                        if (e) begin
                            n_ms[w] = M_IDLE; n_st[w] = 1'b0;
                        end else begin
                            if (b) begin n_pc[w] = br_t; if (h) n_st[w] = 1'b1; end
                            if (x) n_ms[w] = M_PEND;
                        end
                    end
                    M_PEND: begin
                        if (e) begin
                            n_ms[w] = r ? M_IDLE : M_DRAIN; n_st[w] = 1'b0;
                        end else if (b) begin
                            n_pc[w] = br_t;
                            if (r) begin n_ms[w] = M_READY; n_st[w] = 1'b0; end
                            else n_st[w] = 1'b1;
                        end else if (r) begin
                            n_ms[w] = M_READY; n_st[w] = 1'b0;
                            if (!mstale[w] && rsp_a == mpc[w]) n_pc[w] = mpc[w] + INST_BYTES;
                        end
                    end
                    M_DRAIN: if (r) begin n_ms[w] = M_IDLE; n_st[w] = 1'b0; end
                    default: ;
                endcase
            end
            if (g >= 0) n_ptr = (g + 1) % NUM_WARP;
            if (canload) begin
                n_rv = (g >= 0);
                if (g >= 0) begin n_rw = g; n_ra = mpc[g]; end
            end
        end
        @(posedge clk);
        #1;
        ms = n_ms; mpc = n_pc; mstale = n_st;
        mptr = n_ptr; mrv = n_rv; mrw = n_rw; mra = n_ra;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        rst = 1'b1; clear_events();
        start_w = '0; start_a = '0; end_w = '0; br_w = '0; br_t = '0;
        rsp_w = '0; rsp_a = '0;
        avail = '1; stall = '0; ready = 1'b1;
        auto_rsp = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset values
        sample();
        chk("rst_valid", 32'(req_valid), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        advance();
        rst = 1'b0;

        // Start w0 @0x100, fetch, respond, refetch at 0x108
        start_v = 1'b1; start_w = 3'd0; start_a = 32'h100;
        step();
        clear_events();
        sample(); chk("t1_no_req_yet", 32'(req_valid), 32'd0); advance();
        sample();
        chk("t1_req_valid", 32'(req_valid), 32'd1);
        chk("t1_req_addr", req_addr, 32'h100);
        chk("t1_req_wid", 32'(req_wid), 32'd0);
        advance();
        rsp_v = 1'b1; rsp_w = 3'd0; rsp_a = 32'h100;
        sample(); chk("t1_rsp_kept", 32'(drop), 32'd0); advance();
        clear_events();
        sample(); chk("t1_gap", 32'(req_valid), 32'd0); advance();
        sample(); chk("t1_next_addr", req_addr, 32'h108); advance();

        // Branch while PEND drops the in-flight response and refetches the target
        start_v = 1'b1; start_w = 3'd2; start_a = 32'h200;
        step();
        clear_events();
        step();
        sample(); chk("t4_req_addr", req_addr, 32'h200); chk("t4_req_wid", 32'(req_wid), 32'd2); advance();
        br_v = 1'b1; br_w = 3'd2; br_t = 32'h400;
        step();
        clear_events();
        rsp_v = 1'b1; rsp_w = 3'd2; rsp_a = 32'h200;
        sample(); chk("t4_stale_drop", 32'(drop), 32'd1); advance();
        clear_events();
        step();
        sample(); chk("t4_target_addr", req_addr, 32'h400); advance();

        // End while PEND: drains until the dropped response; start to a live warp ignored
        end_v = 1'b1; end_w = 3'd2;
        step();
        clear_events();
        start_v = 1'b1; start_w = 3'd2; start_a = 32'h900;
        sample(); chk("t5_drain_active", 32'(active[2]), 32'd1); advance();
        clear_events();
        rsp_v = 1'b1; rsp_w = 3'd2; rsp_a = 32'h400;
        sample(); chk("t5_drain_drop", 32'(drop), 32'd1); advance();
        clear_events();
        sample(); chk("t5_retired", 32'(active[2]), 32'd0); advance();

        // Memory not ready for 5 cycles: request held, no other warp loaded
        ready = 1'b0;
        start_v = 1'b1; start_w = 3'd3; start_a = 32'h300;
        step();
        clear_events();
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin start_v = 1'b1; start_w = 3'd4; start_a = 32'h500; end
            sample();
            chk("t3_hold_addr", req_addr, 32'h300);
            chk("t3_hold_wid", 32'(req_wid), 32'd3);
            advance();
            clear_events();
        end
        ready = 1'b1;
        sample(); chk("t3_xfer_wid", 32'(req_wid), 32'd3); advance();
        sample(); chk("t3_next_wid", 32'(req_wid), 32'd4); chk("t3_next_addr", req_addr, 32'h500); advance();

        // Stalled warp is skipped until released
        stall = 8'h20;
        start_v = 1'b1; start_w = 3'd5; start_a = 32'h600;
        step();
        start_w = 3'd6; start_a = 32'h700;
        step();
        clear_events();
        step();
        stall = '0;
        sample(); chk("t6_skip_stalled", 32'(req_wid), 32'd6); advance();
        sample(); chk("t6_released_wid", 32'(req_wid), 32'd5); chk("t6_released_addr", req_addr, 32'h600); advance();

        // Randomized traffic against the model
        rst = 1'b1;
        step();
        rst = 1'b0;
        auto_rsp = 1'b1;
        q_wid.delete();
        q_addr.delete();
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 399) == 0);
            start_v = ($urandom_range(0, 3) == 0);
            start_w = 3'($urandom_range(0, 7));
            start_a = $urandom() & 32'hFFFF_FFF8;
            end_v   = ($urandom_range(0, 11) == 0);
            end_w   = 3'($urandom_range(0, 7));
            br_v    = ($urandom_range(0, 7) == 0);
            br_w    = 3'($urandom_range(0, 7));
            br_t    = $urandom() & 32'hFFFF_FFF8;
            for (int w = 0; w < NUM_WARP; w++) begin
                avail[w] = ($urandom_range(0, 7) != 0);
                stall[w] = ($urandom_range(0, 7) == 0);
            end
            ready = ($urandom_range(0, 3) != 0);
            if (q_wid.size() > 0 && $urandom_range(0, 2) == 0) begin
                rsp_v = 1'b1;
                rsp_w = 3'(q_wid.pop_front());
                rsp_a = q_addr.pop_front();
                if ($urandom_range(0, 15) == 0) rsp_a = rsp_a ^ 32'h8;
            end else begin
                rsp_v = 1'b0;
            end
            step();
        end

        // Reset in the middle of traffic clears all outputs next cycle
        clear_events();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        chk("mid_rst_valid", 32'(req_valid), 32'd0);
        chk("mid_rst_active", 32'(active), 32'd0);
        advance();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
